// File: rtl/control_unit_pkg.sv
// Shared definitions for the microprogrammed control unit: select-field codes
// and the dispatch targets used by the instruction encoder.
package control_unit_pkg;

  localparam int STATE_W = 10;

  typedef enum logic [2:0] {
    NS_ENCODE    = 3'b000,
    NS_FETCH     = 3'b001,
    NS_CR        = 3'b010,
    NS_INC       = 3'b011,
    NS_BR_CR_INC = 3'b100,
    NS_BR_CR_ENC = 3'b101,
    NS_WAIT      = 3'b110,
    NS_RSVD      = 3'b111
  } ns_sel_e;

  typedef enum logic [1:0] {
    CS_MOC  = 2'b00,
    CS_COND = 2'b01,
    CS_ONE  = 2'b10,
    CS_ZERO = 2'b11
  } cs_sel_e;

  localparam int ENC_CLS0     = 10;
  localparam int ENC_CLS1     = 11;
  localparam int ENC_CLS5     = 12;
  localparam int ENC_CLS2_B0  = 20;
  localparam int ENC_CLS2_B1  = 30;
  localparam int ENC_CLS3_B0  = 43;
  localparam int ENC_CLS3_B1  = 53;

endpackage

// File: rtl/instruction_encoder.sv
// Combinational decode of the instruction class into a microcode entry state.
// Undefined classes map to state 0 and raise the illegal flag.
module instruction_encoder #(
  parameter int STATE_W = 10
) (
  input  logic [31:0]        ir,
  output logic [STATE_W-1:0] target,
  output logic               illegal
);
  import control_unit_pkg::*;

  always_comb begin
    target  = '0;
    illegal = 1'b0;
    case (ir[27:25])
      3'b000:  target = STATE_W'(ENC_CLS0);
      3'b001:  target = STATE_W'(ENC_CLS1);
      3'b101:  target = STATE_W'(ENC_CLS5);
      3'b010:  target = ir[20] ? STATE_W'(ENC_CLS2_B1) : STATE_W'(ENC_CLS2_B0);
      3'b011:  target = ir[20] ? STATE_W'(ENC_CLS3_B1) : STATE_W'(ENC_CLS3_B0);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/next_state_address_selector.sv
// Sequencer: picks the next microstore address from the control word,
// instruction class and status inputs, and registers it each clock.
module next_state_address_selector #(
  parameter int STATE_W     = 10,
  parameter int FETCH_STATE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ir,
  input  logic [STATE_W-1:0] current_state,
  input  logic [2:0]         ns_sel,
  input  logic [1:0]         cs_sel,
  input  logic               inv,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic               moc,
  input  logic               cond,
  output logic [STATE_W-1:0] next_state,
  output logic               illegal
);
  import control_unit_pkg::*;

  logic [STATE_W-1:0] enc_target;
  logic               enc_illegal;
  logic [STATE_W-1:0] inc;
  logic               c_raw;
  logic               c;
  logic [STATE_W-1:0] ns_d;
  logic               illegal_d;

  instruction_encoder #(.STATE_W(STATE_W)) u_encoder (
    .ir      (ir),
    .target  (enc_target),
    .illegal (enc_illegal)
  );

  assign inc = current_state + STATE_W'(1);

  always_comb begin
    c_raw = 1'b0;
    case (cs_sel_e'(cs_sel))
      CS_MOC:  c_raw = moc;
      CS_COND: c_raw = cond;
      CS_ONE:  c_raw = 1'b1;
      CS_ZERO: c_raw = 1'b0;
      default: c_raw = 1'b0;
    endcase
  end

  assign c = c_raw ^ inv;

  // The illegal flag only matters when the encoder output is the one taken.
  always_comb begin
    ns_d      = '0;
    illegal_d = 1'b0;
    case (ns_sel_e'(ns_sel))
      NS_ENCODE: begin
        ns_d      = enc_target;
        illegal_d = enc_illegal;
      end
      NS_FETCH:     ns_d = STATE_W'(FETCH_STATE);
      NS_CR:        ns_d = cr_addr;
      NS_INC:       ns_d = inc;
      NS_BR_CR_INC: ns_d = c ? cr_addr : inc;
      NS_BR_CR_ENC: begin
        ns_d      = c ? cr_addr : enc_target;
        illegal_d = ~c & enc_illegal;
      end
      NS_WAIT:      ns_d = c ? inc : current_state;
      default:      ns_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_state <= '0;
      illegal    <= 1'b0;
    end else begin
      next_state <= ns_d;
      illegal    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_next_state_address_selector.sv
// Directed-vector bench for the next-state address selector.
module tb_next_state_address_selector;

  localparam int STATE_W = 10;

  logic               clk;
  logic               reset;
  logic [31:0]        ir;
  logic [STATE_W-1:0] current_state;
  logic [2:0]         ns_sel;
  logic [1:0]         cs_sel;
  logic               inv;
  logic [STATE_W-1:0] cr_addr;
  logic               moc;
  logic               cond;
  logic [STATE_W-1:0] next_state;
  logic               illegal;

  int checks = 0;
  int errors = 0;

  next_state_address_selector #(.STATE_W(STATE_W), .FETCH_STATE(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .ir            (ir),
    .current_state (current_state),
    .ns_sel        (ns_sel),
    .cs_sel        (cs_sel),
    .inv           (inv),
    .cr_addr       (cr_addr),
    .moc           (moc),
    .cond          (cond),
    .next_state    (next_state),
    .illegal       (illegal)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ns(input string tag, input int exp_ns, input logic exp_ill);
    check({tag, "_ns"}, 32'(next_state), 32'(exp_ns));
    check({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
  endtask

  function automatic logic [31:0] mk_ir(input logic [2:0] cls, input logic b20);
    logic [31:0] v;
    v = 32'h0;
    v[27:25] = cls;
    v[20] = b20;
    return v;
  endfunction

  initial begin
    reset = 1'b1; ir = '0; current_state = 10'd5; ns_sel = 3'b011;
    cs_sel = 2'b00; inv = 1'b0; cr_addr = '0; moc = 1'b0; cond = 1'b0;

    // Reset held for two edges
    tick(); check_ns("reset1", 0, 1'b0);
    tick(); check_ns("reset2", 0, 1'b0);
    reset = 1'b0; current_state = 10'd0;
    tick(); check_ns("post_reset_inc", 1, 1'b0);

    // Decode
    ns_sel = 3'b000;
    ir = mk_ir(3'b011, 1'b1); tick(); check_ns("dec_011_b1", 53, 1'b0);
    ir = mk_ir(3'b011, 1'b0); tick(); check_ns("dec_011_b0", 43, 1'b0);
    ir = mk_ir(3'b000, 1'b0); tick(); check_ns("dec_000", 10, 1'b0);
    ir = mk_ir(3'b001, 1'b1); tick(); check_ns("dec_001", 11, 1'b0);
    ir = mk_ir(3'b101, 1'b0); tick(); check_ns("dec_101", 12, 1'b0);
    ir = mk_ir(3'b010, 1'b1); tick(); check_ns("dec_010_b1", 30, 1'b0);
    ir = mk_ir(3'b010, 1'b0); tick(); check_ns("dec_010_b0", 20, 1'b0);
    ir = mk_ir(3'b110, 1'b0); tick(); check_ns("dec_110_illegal", 0, 1'b1);
    ns_sel = 3'b011; current_state = 10'd7;
    tick(); check_ns("illegal_one_cycle", 8, 1'b0);
    ns_sel = 3'b000; ir = mk_ir(3'b100, 1'b0); tick(); check_ns("dec_100_illegal", 0, 1'b1);
    ir = mk_ir(3'b111, 1'b1); tick(); check_ns("dec_111_illegal", 0, 1'b1);

    // Conditional decode: illegal only when the encoder path is taken
    ns_sel = 3'b101; cs_sel = 2'b01; cr_addr = 10'd99; cond = 1'b1;
    tick(); check_ns("brenc_taken", 99, 1'b0);
    cond = 1'b0; tick(); check_ns("brenc_enc_illegal", 0, 1'b1);
    ir = mk_ir(3'b001, 1'b0); tick(); check_ns("brenc_enc", 11, 1'b0);

    // Memory wait
    ns_sel = 3'b110; cs_sel = 2'b00; inv = 1'b0; current_state = 10'd3; moc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check_ns("wait_hold", 3, 1'b0);
    end
    moc = 1'b1; tick(); check_ns("wait_done", 4, 1'b0);
    moc = 1'b0;

    // moc ignored when cond is selected
    cs_sel = 2'b01; cond = 1'b0; moc = 1'b1;
    tick(); check_ns("moc_ignored", 3, 1'b0);
    moc = 1'b0;

    // Conditional branch
    ns_sel = 3'b100; cs_sel = 2'b01; cr_addr = 10'd42; current_state = 10'd41;
    cond = 1'b1; tick(); check_ns("br_taken", 42, 1'b0);
    cond = 1'b0; tick(); check_ns("br_inc_41", 42, 1'b0);
    current_state = 10'd20;
    tick(); check_ns("br_inc_20", 21, 1'b0);
    inv = 1'b1; tick(); check_ns("br_inv", 42, 1'b0);
    inv = 1'b0;
    cs_sel = 2'b10; tick(); check_ns("br_const1", 42, 1'b0);
    cs_sel = 2'b11; tick(); check_ns("br_const0", 21, 1'b0);

    // Wrap, fetch, reserved, control-register jump
    ns_sel = 3'b011; current_state = 10'd1023;
    tick(); check_ns("inc_wrap", 0, 1'b0);
    ns_sel = 3'b001; tick(); check_ns("fetch", 1, 1'b0);
    ns_sel = 3'b111; tick(); check_ns("reserved", 0, 1'b0);
    ns_sel = 3'b010; cr_addr = 10'd777; tick(); check_ns("cr_jump", 777, 1'b0);

    // Reset mid-wait
    ns_sel = 3'b110; cs_sel = 2'b00; current_state = 10'd3; moc = 1'b0;
    tick(); check_ns("wait_pre_reset", 3, 1'b0);
    reset = 1'b1; moc = 1'b1;
    tick(); check_ns("reset_mid_wait", 0, 1'b0);
    reset = 1'b0; moc = 1'b0;
    tick(); check_ns("wait_after_reset", 3, 1'b0);

    // Reset mid-decode of an illegal class
    ns_sel = 3'b000; ir = mk_ir(3'b110, 1'b0); reset = 1'b1;
    tick(); check_ns("reset_mid_decode", 0, 1'b0);
    reset = 1'b0;
    tick(); check_ns("decode_after_reset", 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/next_state_address_selector.md
# next_state_address_selector

Sequencing half of the microprogrammed control unit. Each clock it chooses the next control-store address from the control-word fields of the current state, the instruction register and status inputs, then registers it onto `next_state`. That bus drives the microstore address input. The microstore returns the current state's control word combinationally, which closes the one-state-per-cycle loop.

## Interface
- `STATE_W`, default 10: state address width; must match the microstore.
- `FETCH_STATE`, default 1: fixed fetch-entry state selected by `ns_sel`=001.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, synchronous, active-high.
- `ir` input 32: instruction register contents; bits [27:25] and [20] are used.
- `current_state` input STATE_W: state currently presented by the microstore.
- `ns_sel` input 3: next-state select field of the control word.
- `cs_sel` input 2: condition-select field of the control word.
- `inv` input 1: condition-invert bit of the control word.
- `cr_addr` input STATE_W: control-register target address field of the control word.
- `moc` input 1: memory operation complete.
- `cond` input 1: branch condition result from the condition tester.
- `next_state` output STATE_W: registered address driven to the microstore.
- `illegal` output 1: registered; high for one cycle after the encoder resolves an undefined class.

## Operation
- Condition source `c_raw` by `cs_sel`: 00 selects `moc`, 01 selects `cond`, 10 is constant 1, 11 is constant 0. Effective condition `c = c_raw ^ inv`.
- Incrementer: `inc = current_state + 1`, computed modulo 2^STATE_W. The maximum state wraps to 0.
- Encoder, keyed on `ir[27:25]`:
  - 000 → 10; 001 → 11; 101 → 12.
  - 010 → 30 if `ir[20]`=1, else 20.
  - 011 → 53 if `ir[20]`=1, else 43.
  - 100, 110, 111 → 0, and `illegal_d`=1.
- Selection by `ns_sel`:
  - 000: encoder output (unconditional decode).
  - 001: `FETCH_STATE`.
  - 010: `cr_addr`.
  - 011: `inc`.
  - 100: `c` ? `cr_addr` : `inc` (conditional branch).
  - 101: `c` ? `cr_addr` : encoder (conditional decode).
  - 110: `c` ? `inc` : `current_state` (wait/hold, used with `cs_sel`=00 for memory waits).
  - 111: reserved, selects state 0.
- `illegal_d` is asserted only when the encoder output is actually selected, i.e. `ns_sel`=000, or `ns_sel`=101 with `c`=0.

## Timing
- Reset: when `reset`=1 at a rising edge, `next_state` <= 0 and `illegal` <= 0. Reset overrides every other input, including mid-wait and mid-decode.
- Latency: one cycle from control-word fields to `next_state`. The selection path is purely combinational from the inputs to the register D input.
- No combinational path from any input to `next_state`; `next_state` is a register output only.
- Hold state (`ns_sel`=110, `c`=0): `next_state` re-registers `current_state` every cycle. There is no timeout.
- `moc` is sampled only on the edge where `cs_sel`=00 selects it. A `moc` pulse outside a wait state has no effect.
- `illegal` reflects the previous edge's decision and stays high exactly one cycle per illegal decode.
- Inputs with X/Z values are out of scope; the bench drives known values.

## Structure
- Shared package `control_unit_pkg`:
  - `STATE_W`.
  - `ns_sel` codes: `NS_ENCODE`, `NS_FETCH`, `NS_CR`, `NS_INC`, `NS_BR_CR_INC`, `NS_BR_CR_ENC`, `NS_WAIT`, `NS_RSVD`.
  - `cs_sel` codes: `CS_MOC`, `CS_COND`, `CS_ONE`, `CS_ZERO`.
  - Encoder target-state constants: 10, 11, 12, 20, 30, 43, 53.
- One sub-module: `instruction_encoder`. It is purely combinational: `ir` in, target state and illegal flag out. It is kept separate so the decode map can be extended independently.
- The top level holds the condition mux, incrementer, next-state mux and output registers.

## Test plan
- Reset: `reset`=1 for 2 cycles with `ns_sel`=011 and `current_state`=5 → `next_state`=0 and `illegal`=0 on both edges. Then release, `current_state`=0 → `next_state`=1.
- Decode: `ns_sel`=000 with `ir[27:25]`=011, `ir[20]`=1 → `next_state`=53. Repeat with `ir[20]`=0 → 43. With `ir[27:25]`=110 → 0 and `illegal`=1 for exactly one cycle.
- Memory wait: `ns_sel`=110, `cs_sel`=00, `inv`=0, `current_state`=3, `moc`=0 for 4 cycles → `next_state` stays 3. Then `moc`=1 → `next_state`=4 next edge.
- Conditional branch: `ns_sel`=100, `cs_sel`=01, `cr_addr`=42, `current_state`=41:
  - `cond`=1 → 42.
  - `cond`=0 → 42 (41+1).
  - Repeat with `current_state`=20: `cond`=0 gives 21; `inv`=1 with `cond`=0 gives 42.
- Wrap and reserved: `ns_sel`=011 with `current_state`=1023 → `next_state`=0. `ns_sel`=111 → 0. `ns_sel`=001 → 1.
- Reset mid-wait: hold in `NS_WAIT` at state 3, assert `reset` for one edge with `moc`=1 → `next_state`=0, not 4.
